// File: rtl/keypad_calc_core.sv
// keypad_calc_core: debounced hex keypad front end driving a chained unsigned + - * calculator.
module keypad_calc_core #(
  parameter int WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_pressed,
  input  logic [3:0]       keypad_out,
  output logic [WIDTH-1:0] reg_display,
  output logic             err,
  output logic             key_valid,
  output logic [1:0]       calc_state
);
  typedef enum logic [1:0] {ENTER_A, ENTER_B, RESULT, ERROR} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] K_CE = 4'hD, K_EQ = 4'hE, K_AC = 4'hF;
  logic [1:0]       sync_q;
  logic             armed_q, key_valid_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       key_q;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] entry_q, entry_d, a_q, a_d, res_q, res_d, disp_q, disp_d;
  logic [1:0]       op_q, op_d;
  logic             typed_q, typed_d;
  // armed means waiting for a press, so the level being counted toward equals armed_q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q      <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], key_pressed};
      key_valid_q <= 1'b0;
      if (sync_q[1] != armed_q) cnt_q <= '0;
      else if (cnt_q == LAST) begin
        cnt_q       <= '0;
        armed_q     <= !armed_q;
        key_valid_q <= armed_q;
        if (armed_q) key_q <= keypad_out;
      end else cnt_q <= cnt_q + 1'b1;
    end
  logic             is_digit, is_op, entry_fit, alu_err, clr;
  logic [1:0]       op_new;
  logic [WIDTH+3:0] entry_ext;
  logic [WIDTH-1:0] entry_next, alu_res;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  assign is_digit   = key_q < 4'd10;
  assign is_op      = key_q inside {4'hA, 4'hB, 4'hC};
  assign op_new     = 2'(key_q - 4'hA);
  assign entry_ext  = (WIDTH+4)'(entry_q) * (WIDTH+4)'(10) + (WIDTH+4)'(key_q);
  assign entry_fit  = entry_ext[WIDTH+3:WIDTH] == 4'd0;
  assign entry_next = entry_fit ? entry_ext[WIDTH-1:0] : entry_q;
  assign sum        = {1'b0, a_q} + {1'b0, entry_q};
  assign prod       = (2*WIDTH)'(a_q) * (2*WIDTH)'(entry_q);
  assign alu_res    = op_q == 2'd0 ? sum[WIDTH-1:0] : op_q == 2'd1 ? a_q - entry_q : prod[WIDTH-1:0];
  assign alu_err    = op_q == 2'd0 ? sum[WIDTH] : op_q == 2'd1 ? entry_q > a_q : |prod[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    a_d     = a_q;
    res_d   = res_q;
    op_d    = op_q;
    typed_d = typed_q;
    clr     = 1'b0;
    if (key_valid_q)
      case (state_q)
        ENTER_A:
          if (is_digit) entry_d = entry_next;
          else if (is_op) begin
            a_d     = entry_q;
            op_d    = op_new;
            entry_d = '0;
            typed_d = 1'b0;
            state_d = ENTER_B;
          end else if (key_q == K_CE || key_q == K_AC) entry_d = '0;
        ENTER_B:
          if (is_digit) begin
            entry_d = entry_next;
            typed_d = 1'b1;
          end else if (is_op || key_q == K_EQ) begin
            if (alu_err) state_d = ERROR;
            else if (is_op) begin
              a_d     = alu_res;
              op_d    = op_new;
              entry_d = '0;
              typed_d = 1'b0;
            end else begin
              res_d   = alu_res;
              state_d = RESULT;
            end
          end else if (key_q == K_CE) begin
            entry_d = '0;
            typed_d = 1'b1;
          end else if (key_q == K_AC) clr = 1'b1;
        RESULT:
          if (is_digit) begin
            entry_d = WIDTH'(key_q);
            state_d = ENTER_A;
          end else if (is_op) begin
            a_d     = res_q;
            op_d    = op_new;
            entry_d = '0;
            typed_d = 1'b0;
            state_d = ENTER_B;
          end else if (key_q == K_CE || key_q == K_AC) clr = 1'b1;
        default: clr = key_q == K_AC;
      endcase
    if (clr) begin
      state_d = ENTER_A;
      entry_d = '0;
      a_d     = '0;
      res_d   = '0;
      op_d    = '0;
      typed_d = 1'b0;
    end
    // until the first digit of the second operand, show the running value
    disp_d = state_d == ERROR ? '1 : state_d == RESULT ? res_d :
             (state_d == ENTER_B && !typed_d) ? a_d : entry_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ENTER_A;
      entry_q <= '0;
      a_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      typed_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      a_q     <= a_d;
      res_q   <= res_d;
      op_q    <= op_d;
      typed_q <= typed_d;
      disp_q  <= disp_d;
    end
  assign reg_display = disp_q;
  assign err         = state_q == ERROR;
  assign key_valid   = key_valid_q;
  assign calc_state  = state_q;
endmodule

// File: tb/tb_keypad_calc_core.sv
// tb_keypad_calc_core: directed keypad sequences with hand-computed display/state expectations.
module tb_keypad_calc_core;
  logic       clk = 1'b0, rst_n = 1'b0, key_pressed = 1'b0;
  logic [3:0] keypad_out = 4'h0;
  logic [9:0] reg_display;
  logic       err, key_valid;
  logic [1:0] calc_state;
  int n_chk = 0, n_pass = 0, kv_cnt = 0, kv0;
  keypad_calc_core #(.WIDTH(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .keypad_out(keypad_out),
    .reg_display(reg_display), .err(err), .key_valid(key_valid), .calc_state(calc_state)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (key_valid) kv_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    keypad_out  = c;
    key_pressed = 1'b1;
    repeat (8) @(negedge clk);
    key_pressed = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic keys(input logic [31:0] ks, input int n);
    for (int i = 0; i < n; i++) press(ks[4*(n-1-i) +: 4]);
  endtask
  initial begin
    #2;
    chk("rst_disp", reg_display, 0);
    chk("rst_state", calc_state, 0);
    chk("rst_err", err, 0);
    chk("rst_kv", key_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int w = 1; w <= 3; w++) begin
      keypad_out  = 4'(w);
      key_pressed = 1'b1;
      repeat (w) @(negedge clk);
      key_pressed = 1'b0;
      repeat (8) @(negedge clk);
    end
    chk("glitch_kv", kv_cnt, 0);
    keypad_out  = 4'hF;
    key_pressed = 1'b1;
    repeat (5) @(negedge clk);
    chk("kv_edge5", key_valid, 0);
    @(negedge clk) chk("kv_edge6", key_valid, 1);
    @(negedge clk) chk("kv_edge7", key_valid, 0);
    @(negedge clk) key_pressed = 1'b0;
    repeat (8) @(negedge clk);
    chk("clean_kv", kv_cnt, 1);
    keys(32'h12, 2);
    chk("t2_a", reg_display, 12);
    keys(32'hA34, 3);
    chk("t2_b", reg_display, 34);
    press(4'hE);
    chk("t2_res", reg_display, 46);
    chk("t2_state", calc_state, 2);
    chk("t2_err", err, 0);
    keys(32'h3A4A, 4);
    chk("t3_chain", reg_display, 7);
    chk("t3_chst", calc_state, 1);
    keys(32'h5E, 2);
    chk("t3_res", reg_display, 12);
    keys(32'h5B7E, 4);
    chk("t3_err", err, 1);
    chk("t3_edisp", reg_display, 10'h3FF);
    chk("t3_est", calc_state, 3);
    press(4'h5);
    chk("t3_errhold", calc_state, 3);
    press(4'hF);
    chk("t3_ac_disp", reg_display, 0);
    chk("t3_ac_st", calc_state, 0);
    keys(32'h1000C2E, 7);
    chk("t4_moverr", err, 1);
    chk("t4_most", calc_state, 3);
    press(4'hF);
    keys(32'h10239, 5);
    chk("t4_cap", reg_display, 1023);
    chk("t4_capst", calc_state, 0);
    chk("t4_caperr", err, 0);
    press(4'hF);
    press(4'h1);
    chk("t5_pre", reg_display, 1);
    keypad_out  = 4'h2;
    key_pressed = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_disp", reg_display, 0);
    chk("t5_kv", key_valid, 0);
    chk("t5_st", calc_state, 0);
    @(negedge clk) rst_n = 1'b1;
    kv0 = kv_cnt;
    repeat (20) @(negedge clk);
    chk("t5_held", kv_cnt - kv0, 0);
    key_pressed = 1'b0;
    repeat (8) @(negedge clk);
    press(4'h5);
    chk("t5_new", kv_cnt - kv0, 1);
    chk("t5_ndisp", reg_display, 5);
    press(4'hF);
    keys(32'h12A34E, 6);
    chk("t6_res", reg_display, 46);
    press(4'h7);
    chk("t6_dig", reg_display, 7);
    chk("t6_dst", calc_state, 0);
    keys(32'hF12A34E, 7);
    keys(32'hB6E, 3);
    chk("t6_sub", reg_display, 40);
    chk("t6_subst", calc_state, 2);
    keys(32'hC3E, 3);
    chk("t6_mul", reg_display, 120);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
